// File: rtl/sqrt_fp_recon_if.sv
// Request/result bundle for the fixed-point square-root reconstructor.
// start is sampled only while busy=0; valid is a one-cycle pulse and the results hold until the next one.
interface sqrt_fp_recon_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] rad_out;
  logic             exact;
  logic             ovf;

  modport master (output start, root, rem, input busy, valid, rad_out, exact, ovf);
  modport slave  (input start, root, rem, output busy, valid, rad_out, exact, ovf);
endinterface

// File: rtl/sqrt_fp_recon.sv
// Rebuilds a fixed-point radicand from a root/remainder pair: rad = (root*root + rem) >> FBITS.
// Uses a serial LSB-first shift-add multiply with a constant latency of WIDTH+1 clocks.
module sqrt_fp_recon #(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  sqrt_fp_recon_if.slave     bus,
  output logic [1:0]         dbg_state
);
  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   rad_q, rad_d;
  logic               exact_q, exact_d;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      sum;

  // State register plus datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      rad_q    <= '0;
      exact_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      rad_q    <= rad_d;
      exact_q  <= exact_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_MUL;
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Full-width sum so that neither overflow nor the discarded fraction is lost.
  assign sum = acc_q + {{(AW - WIDTH){1'b0}}, rem_q};

  // Datapath and output logic.
  always_comb begin
    cnt_d    = cnt_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    rad_d    = rad_q;
    exact_d  = exact_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mplier_d = bus.root;
          mcand_d  = {{WIDTH{1'b0}}, bus.root};
          rem_d    = bus.rem;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
          busy_d   = 1'b1;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + {1'b0, mcand_q};
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
      S_FIN: begin
        rad_d   = sum[WIDTH+FBITS-1:FBITS];
        exact_d = (sum[FBITS-1:0] == '0);
        ovf_d   = |sum[AW-1:WIDTH+FBITS];
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.valid   = valid_q;
  assign bus.rad_out = rad_q;
  assign bus.exact   = exact_q;
  assign bus.ovf     = ovf_q;
  assign dbg_state   = state_q;
endmodule
